// File: rtl/button_event_pkg.sv
// Shared types and defaults for push-button event decoding.
// Latency: n/a (declarations only).
// Backpressure: n/a; consumers take every pulse.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } btn_state_t;

    // Defaults sized for the game top clock; one button_event per debouncer.
    localparam int unsigned HOLD_CYCLES_DEF   = 1_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 250_000;

    // Counter width able to hold the larger of the two thresholds.
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned repeat_cycles);
        int unsigned mx;
        mx = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/button_event_if.sv
// Button level in, single-cycle event pulses and held level out.
// Latency: n/a (signal bundle only).
// Backpressure: none; pulses are fire-and-forget.
interface button_event_if;

    logic pb_debounced;
    logic press_pulse;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;
    logic is_held;

    // Side that drives the button level and consumes events.
    modport master (
        output pb_debounced,
        input  press_pulse,
        input  release_pulse,
        input  long_press,
        input  repeat_pulse,
        input  is_held
    );

    // Event decoder side.
    modport slave (
        input  pb_debounced,
        output press_pulse,
        output release_pulse,
        output long_press,
        output repeat_pulse,
        output is_held
    );

endinterface

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long-press/auto-repeat pulses.
// Latency: every output is registered, one cycle after the sample that causes it.
// Backpressure: none; optional auto-repeat enabled by defining BUTTON_AUTOREPEAT_EN.
module button_event
    import btn_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    button_event_if.slave  btn
);

    localparam int unsigned       CNT_W     = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    // Counter is 1 after the first high sample, so the Nth high sees N-1.
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
    // Counter is 0 in the first HOLD cycle, so a period ends when it reads R-1.
    localparam logic [CNT_W-1:0]  REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             held_q, held_d;
`ifdef BUTTON_AUTOREPEAT_EN
    logic             repeat_q, repeat_d;
`endif

    // Next-state decode; a low sample always wins over any threshold match.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_d    = btn.pb_debounced;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        held_d    = held_q;
`ifdef BUTTON_AUTOREPEAT_EN
        repeat_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                held_d = 1'b0;
                // prev_q resets high, so a button held through reset is ignored.
                if (btn.pb_debounced && !prev_q) begin
                    state_d = PRESS;
                    cnt_d   = CNT_ONE;
                    press_d = 1'b1;
                end
            end
            PRESS: begin
                if (!btn.pb_debounced) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                    held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (!btn.pb_debounced) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                end else begin
`ifdef BUTTON_AUTOREPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset emits no release and arms the lockout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
`ifdef BUTTON_AUTOREPEAT_EN
            repeat_q  <= repeat_d;
`endif
        end
    end

    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.long_press    = long_q;
    assign btn.is_held       = held_q;
`ifdef BUTTON_AUTOREPEAT_EN
    assign btn.repeat_pulse  = repeat_q;
`else
    assign btn.repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: driver pushes expected outputs, monitor compares.
// Latency: expected vector for each sample is checked one cycle later.
// Backpressure: none; the monitor checks every cycle's outputs.
module tb_button_event;
    import btn_pkg::*;

    localparam int unsigned H = 8;
    localparam int unsigned R = 4;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    button_event_if bif();

    button_event #(
        .HOLD_CYCLES   (H),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rst;
        logic press;
        logic rel;
        logic lng;
        logic rep;
        logic held;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_cycles = 0;

    // Reference model: a press is "active" from the rising edge until the
    // first low sample; hi_len counts consecutive high samples since then.
    bit   m_prev   = 1'b1;
    bit   m_active = 1'b0;
    int   m_hi     = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, n_cycles, act, exp);
        end
    endtask

    // Apply one cycle of inputs and queue the outputs the rules require next cycle.
    task automatic step(input logic r, input logic p);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        bif.pb_debounced = p;
        @(posedge clk);
        n_cycles++;
        e = '0;
        e.rst = !r;
        if (!r) begin
            m_prev   = 1'b1;
            m_active = 1'b0;
            m_hi     = 0;
        end else begin
            if (!m_active) begin
                if (p && !m_prev) begin
                    e.press  = 1'b1;
                    m_active = 1'b1;
                    m_hi     = 1;
                end
            end else if (!p) begin
                e.rel    = 1'b1;
                m_active = 1'b0;
                m_hi     = 0;
            end else begin
                m_hi++;
                e.lng  = (m_hi == int'(H));
                e.held = (m_hi >= int'(H));
                e.rep  = REP_EN && (m_hi > int'(H)) && (((m_hi - int'(H)) % int'(R)) == 0);
            end
            m_prev = p;
        end
        sb_q.push_back(e);
    endtask

    task automatic run(input logic r, input logic p, input int n);
        for (int i = 0; i < n; i++) step(r, p);
    endtask

    // Monitor: compare the registered outputs against the queued expectation,
    // plus structural rules on the pulse stream itself.
    logic last_press = 1'b0, last_rel = 1'b0, last_lng = 1'b0;
    bit   armed_press = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("press_pulse",   bif.press_pulse,   e.press);
                chk("release_pulse", bif.release_pulse, e.rel);
                chk("long_press",    bif.long_press,    e.lng);
                chk("repeat_pulse",  bif.repeat_pulse,  e.rep);
                chk("is_held",       bif.is_held,       e.held);
                chk("press_rel_overlap", bif.press_pulse & bif.release_pulse, 1'b0);
                chk("press_width",   bif.press_pulse & last_press, 1'b0);
                chk("release_width", bif.release_pulse & last_rel, 1'b0);
                chk("long_width",    bif.long_press & last_lng, 1'b0);
                if (e.rst) armed_press = 1'b0;
                if (bif.press_pulse) begin
                    chk("press_after_press", armed_press, 1'b0);
                    armed_press = 1'b1;
                end
                if (bif.release_pulse) begin
                    chk("release_without_press", armed_press, 1'b1);
                    armed_press = 1'b0;
                end
                last_press = bif.press_pulse;
                last_rel   = bif.release_pulse;
                last_lng   = bif.long_press;
            end
        end
    end

    initial begin
        logic lvl;
        int   len;
        bif.pb_debounced = 1'b0;

        // Reset with button low, then a short 3-cycle press.
        run(1'b0, 1'b0, 2);
        run(1'b1, 1'b0, 2);
        run(1'b1, 1'b1, 3);
        run(1'b1, 1'b0, 4);

        // Seven highs: one short of the hold threshold.
        run(1'b1, 1'b1, 7);
        run(1'b1, 1'b0, 3);

        // Twenty highs: long press, then repeats if enabled.
        run(1'b1, 1'b1, 20);
        run(1'b1, 1'b0, 3);

        // Button held across reset release: locked out until low-then-high.
        run(1'b0, 1'b1, 2);
        run(1'b1, 1'b1, 3);
        run(1'b1, 1'b0, 2);
        run(1'b1, 1'b1, 3);
        run(1'b1, 1'b0, 2);

        // Reset during HOLD: no release pulse, lockout afterwards.
        run(1'b1, 1'b1, 10);
        run(1'b0, 1'b1, 1);
        run(1'b1, 1'b1, 5);
        run(1'b1, 1'b0, 2);
        run(1'b1, 1'b1, 2);
        run(1'b1, 1'b0, 2);

        // Random level runs with occasional resets.
        lvl = 1'b0;
        while (n_cycles < 10000) begin
            if ($urandom_range(0, 49) == 0) begin
                run(1'b0, lvl, int'($urandom_range(1, 3)));
            end else begin
                lvl = ~lvl;
                len = int'($urandom_range(1, 24));
                run(1'b1, lvl, len);
            end
        end
        run(1'b1, 1'b0, 2);

        // Let the monitor drain the last expectation.
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
